// File: rtl/alu_mc_pkg.sv
// Shared encodings for the multi-cycle ALU: opcode values and controller states.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_XOR   = 4'd3,
        OP_NOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SUB   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLTU  = 4'd10,
        OP_LUI   = 4'd11,
        OP_MULLO = 4'd12,
        OP_MULHU = 4'd13,
        OP_DIVU  = 4'd14,
        OP_REMU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes 12..15 run on the iterative datapath.
    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide, one step per cycle.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt,
    output logic             last
);

    logic             running;
    logic             div_mode;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] operand_b;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, operand_b};
        shifted = {acc, mq[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand_b});
        // When the divisor fits the difference is below the divisor, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - operand_b;
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (div_mode) begin
            hi_nxt = fits ? diff : shifted[WIDTH-1:0];
            lo_nxt = {mq[WIDTH-2:0], fits};
        end else if (mq[0]) begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], mq[WIDTH-1:1]};
        end else begin
            hi_nxt = {1'b0, acc[WIDTH-1:1]};
            lo_nxt = {acc[0], mq[WIDTH-1:1]};
        end
        last = running && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running   <= 1'b0;
            div_mode  <= 1'b0;
            acc       <= '0;
            mq        <= '0;
            operand_b <= '0;
            cnt       <= '0;
        end else if (start) begin
            running   <= 1'b1;
            div_mode  <= is_div;
            acc       <= '0;
            mq        <= a;
            operand_b <= b;
            cnt       <= '0;
        end else if (running) begin
            acc     <= hi_nxt;
            mq      <= lo_nxt;
            cnt     <= last ? '0 : cnt + 1'b1;
            running <= !last;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative multiply/divide.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] crs,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             div0,
    output state_e           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // the producer holds its fields stable while valid is high and ready is low.

    state_e           state;
    state_e           state_nxt;
    logic             start_iter;
    logic             accept;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] mc_res;
    alu_op_e          op_q;
    logic             b_zero_q;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = (state == ST_IDLE);
        start_iter = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_multi_cycle(alu_op)) begin
                        state_nxt  = ST_BUSY;
                        start_iter = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_BUSY: if (iter_last) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        single_res = '0;
        case (alu_op_e'(alu_op))
            OP_AND:  single_res = crs & alu_in;
            OP_OR:   single_res = crs | alu_in;
            OP_ADD:  single_res = crs + alu_in;
            OP_XOR:  single_res = crs ^ alu_in;
            OP_NOR:  single_res = ~(crs | alu_in);
            OP_SLL:  single_res = alu_in << shamt;
            OP_SRL:  single_res = alu_in >> shamt;
            OP_SRA:  single_res = WIDTH'($signed(alu_in) >>> shamt);
            OP_SUB:  single_res = crs - alu_in;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(crs) < $signed(alu_in))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (crs < alu_in)};
            OP_LUI:  single_res = {alu_in[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        mc_res = '0;
        case (op_q)
            OP_MULLO, OP_DIVU: mc_res = iter_lo;
            OP_MULHU, OP_REMU: mc_res = iter_hi;
            default:           mc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out  <= '0;
            zero     <= 1'b1;
            div0     <= 1'b0;
            op_q     <= OP_AND;
            b_zero_q <= 1'b0;
        end else if (accept) begin
            op_q     <= alu_op_e'(alu_op);
            b_zero_q <= (alu_in == '0);
            if (!is_multi_cycle(alu_op)) begin
                alu_out <= single_res;
                zero    <= (single_res == '0);
                div0    <= 1'b0;
            end
        end else if (iter_last) begin
            alu_out <= mc_res;
            zero    <= (mc_res == '0);
            div0    <= (op_q == OP_DIVU || op_q == OP_REMU) && b_zero_q;
        end
    end

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .CW    (SHW)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_iter),
        .is_div (alu_op[1]),
        .a      (crs),
        .b      (alu_in),
        .hi_nxt (iter_hi),
        .lo_nxt (iter_lo),
        .last   (iter_last)
    );

endmodule
